fmap_streamer: RTL and testbench
================================

Name: fmap_streamer

Overview:
- Reads the full 2-D output feature map that the convolution stage writes, and streams it out one element per handshake, row-major.
- Sits after the convolution stage and is the reader side of its parallel matrix-plus-done interface.
- Captures a snapshot when the writer signals completion, then drains it over a valid/ready stream towards pooling, FC or memory-writer stages.

Parameters:
- OUT_SIZE, 5, side length of the square feature map (SIZE-SIZEKer+1 of the producing stage); must be >= 2.
- WIDTH_BIT, 8, signed element width.
- IDX_W (localparam), max($clog2(OUT_SIZE),1), width of the row/column index outputs.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- fmap_in  input  signed [WIDTH_BIT-1:0] x [OUT_SIZE][OUT_SIZE]  feature map from the writer, indexed [row][col].
- done_in  input  1  writer completion flag; level or pulse accepted.
- m_data  output  signed [WIDTH_BIT-1:0]  current element.
- m_valid  output  1  m_data, m_row, m_col and m_last are valid.
- m_ready  input  1  downstream accepts the element when m_valid & m_ready.
- m_last  output  1  current element is (OUT_SIZE-1, OUT_SIZE-1).
- m_row  output  IDX_W  row index of the current element.
- m_col  output  IDX_W  column index of the current element.
- busy  output  1  a frame is being streamed.
- overrun  output  1  sticky error: a new frame was signalled while busy and was dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears state to IDLE, row and col counters, snapshot, and done_q (the done_in delay flop).
  - Outputs: m_valid=0, m_data=0, m_last=0, m_row=0, m_col=0, busy=0, overrun=0.
  - Reset asserted mid-stream aborts the frame immediately; nothing resumes after release.
  - done_in high through reset release counts as a new edge only after done_q has sampled 0 once; no frame starts until done_in goes low then high.
- Frame start event:
  - start = done_in & ~done_q, sampled on the clock. done_q updates every cycle.
- State IDLE:
  - On start: snapshot <= fmap_in (all elements, same edge), row=col=0, go to STREAM.
  - The snapshot is taken at the start edge. Later changes to fmap_in do not affect the frame.
- State STREAM:
  - m_valid=1, busy=1.
  - m_data=snapshot[row][col], m_row=row, m_col=col.
  - m_last=1 iff row==OUT_SIZE-1 and col==OUT_SIZE-1.
- Handshake (m_valid & m_ready at an edge):
  - col increments; when col==OUT_SIZE-1 it wraps to 0 and row increments.
  - On the last element, go to IDLE with counters cleared.
- Stall:
  - While m_valid & ~m_ready, m_data, m_row, m_col and m_last hold stable. m_valid never drops before a handshake.
- Outputs in IDLE:
  - m_valid=0, busy=0; m_data, m_last, m_row and m_col are forced to 0.
- Latency and throughput:
  - start sampled at edge N gives m_valid=1 with element (0,0) after edge N.
  - With m_ready held high, the frame takes exactly OUT_SIZE*OUT_SIZE cycles; m_last is high in the final cycle.
- Boundary conditions:
  - start while in STREAM and not on the last handshake: frame dropped, overrun set to 1, snapshot untouched. overrun clears only on reset.
  - start in the same cycle as the last-element handshake: not an overrun. Snapshot reloads, counters go to 0,0, state stays STREAM, and m_valid stays high with no bubble.
  - done_in held high for many cycles yields exactly one frame.
  - No arithmetic on data: m_data is a bit-exact copy, sign preserved.

Test Plan:
- Reset, then fmap_in[r][c] = 10*r+c (OUT_SIZE=5), pulse done_in, m_ready=1 -> 25 beats, values 0,1,2,3,4,10,...,44 in order; m_row/m_col match; m_last only on value 44; m_valid drops the cycle after.
- Same frame, m_ready toggling 1,0,0,1 repeating -> identical 25-value sequence; outputs stable across every stall cycle; no duplicated or skipped beat.
- Change fmap_in to all -1 two cycles after start -> streamed values are still 10*r+c; then a new done_in edge streams all -1 (m_data = 8'hFF, signed -1).
- Pulse done_in again at beat 7 of a frame -> overrun=1 and stays 1; current frame completes unchanged; no second frame follows.
- Pulse done_in in the cycle of the handshake on value 44 -> m_valid stays high; the next beat is (0,0) of the new snapshot; overrun stays 0.
- Assert reset at beat 12 -> m_valid, busy, m_row and m_col go to 0 immediately (asynchronous); after release with done_in held high -> no frame until done_in goes low then high.

Source files
------------

// File: rtl/fmap_streamer_if.sv
// Element stream from the feature-map reader towards downstream stages.
//   m_data  : current element (signed, bit-exact copy of the snapshot)
//   m_valid : m_data/m_row/m_col/m_last are valid
//   m_ready : downstream accepts on m_valid & m_ready
//   m_last  : current element is the bottom-right corner of the map
//   m_row   : row index of the current element
//   m_col   : column index of the current element
interface fmap_streamer_if #(
  parameter int unsigned WIDTH_BIT = 8,
  parameter int unsigned IDX_W     = 3
);
  logic signed [WIDTH_BIT-1:0] m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last;
  logic        [IDX_W-1:0]     m_row;
  logic        [IDX_W-1:0]     m_col;

  modport master (output m_data, m_valid, m_last, m_row, m_col, input m_ready);
  modport slave  (input m_data, m_valid, m_last, m_row, m_col, output m_ready);
endinterface

// File: rtl/fmap_streamer.sv
// Feature-map streamer: snapshots the full OUT_SIZE x OUT_SIZE map written by
// the convolution stage on the rising edge of done_in, then drains it
// row-major over a valid/ready stream.
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high reset
//   fmap_in  : feature map from the writer, [row][col]
//   done_in  : writer completion flag (level or pulse)
//   m        : element stream (master side)
//   busy     : a frame is being streamed
//   overrun  : sticky, a frame was signalled while busy and dropped
module fmap_streamer #(
  parameter int unsigned OUT_SIZE  = 5,
  parameter int unsigned WIDTH_BIT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [WIDTH_BIT-1:0] fmap_in [OUT_SIZE][OUT_SIZE],
  input  logic                        done_in,
  fmap_streamer_if.master             m,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned IDX_W = ($clog2(OUT_SIZE) > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(OUT_SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                      state, state_n;
  logic        [IDX_W-1:0]     row, col, row_n, col_n;
  logic signed [WIDTH_BIT-1:0] snapshot [OUT_SIZE][OUT_SIZE];
  logic signed [WIDTH_BIT-1:0] elem_n;
  logic                        done_q;
  logic                        armed;
  logic                        start;
  logic                        load;
  logic                        at_last;
  logic                        overrun_n;

  // armed blocks a done_in level held through reset release from counting as an edge
  assign start   = done_in & ~done_q & armed;
  assign at_last = (row == IDX_MAX) && (col == IDX_MAX);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, counter advance, snapshot load and overrun detection
  always_comb begin
    state_n   = state;
    row_n     = row;
    col_n     = col;
    load      = 1'b0;
    overrun_n = overrun;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          row_n   = '0;
          col_n   = '0;
          state_n = STREAM;
        end
      end
      STREAM: begin
        // m_valid is high throughout STREAM, so m_ready alone is the handshake
        if (m.m_ready) begin
          if (at_last) begin
            row_n = '0;
            col_n = '0;
            // a start coinciding with the final handshake chains straight into the next frame
            if (start) load = 1'b1;
            else       state_n = IDLE;
          end else if (col == IDX_MAX) begin
            col_n = '0;
            row_n = row + IDX_W'(1);
          end else begin
            col_n = col + IDX_W'(1);
          end
        end
        if (start && !(m.m_ready && at_last)) overrun_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Element presented after this edge; a fresh load bypasses the snapshot
  always_comb begin
    elem_n = load ? fmap_in[row_n][col_n] : snapshot[row_n][col_n];
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      snapshot  <= '{default: '0};
      done_q    <= 1'b0;
      armed     <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_last  <= 1'b0;
      m.m_row   <= '0;
      m.m_col   <= '0;
    end else begin
      row     <= row_n;
      col     <= col_n;
      done_q  <= done_in;
      armed   <= armed | ~done_in;
      overrun <= overrun_n;
      if (load) snapshot <= fmap_in;
      busy      <= (state_n == STREAM);
      m.m_valid <= (state_n == STREAM);
      if (state_n == STREAM) begin
        m.m_data <= elem_n;
        m.m_last <= (row_n == IDX_MAX) && (col_n == IDX_MAX);
        m.m_row  <= row_n;
        m.m_col  <= col_n;
      end else begin
        m.m_data <= '0;
        m.m_last <= 1'b0;
        m.m_row  <= '0;
        m.m_col  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer (OUT_SIZE=5, WIDTH_BIT=8).
module tb_fmap_streamer;

  localparam int unsigned N = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              done_in;
  logic signed [7:0] fmap_in [N][N];
  logic              busy;
  logic              overrun;
  int                total = 0;
  int                bad   = 0;

  fmap_streamer_if #(.WIDTH_BIT(8), .IDX_W(3)) s ();

  fmap_streamer #(.OUT_SIZE(N), .WIDTH_BIT(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .fmap_in (fmap_in),
    .done_in (done_in),
    .m       (s.master),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  // kind 0: 10*r+c, kind 1: all -1, kind 2: -1-(10*r+c)
  function automatic logic [7:0] ev(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'(10 * r + c);
      1:       return 8'hFF;
      default: return 8'(-1 - (10 * r + c));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        fmap_in[r][c] = ev(kind, r, c);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(s.m_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_data"},  {24'd0, s.m_data}, 32'd0);
    chk({tag, "_last"},  32'(s.m_last),  32'd0);
    chk({tag, "_row"},   32'(s.m_row),   32'd0);
    chk({tag, "_col"},   32'(s.m_col),   32'd0);
  endtask

  // Called at a negedge where beat 0 should be visible; returns at the
  // negedge following the final handshake.
  task automatic drain(input string tag, input int kind, input int rmode,
                       input int pulse_at, input int change_at, input int change_kind,
                       input logic hold, output int nbeats, output int ncyc);
    int beat = 0;
    int cyc  = 0;
    while (beat < int'(N * N) && cyc < 400) begin
      s.m_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      done_in   = hold | ((beat == pulse_at) && s.m_ready);
      if (cyc == change_at) fill(change_kind);
      chk({tag, "_valid"}, 32'(s.m_valid), 32'd1);
      chk({tag, "_busy"},  32'(busy),      32'd1);
      chk({tag, "_data"},  {24'd0, s.m_data}, {24'd0, ev(kind, beat / int'(N), beat % int'(N))});
      chk({tag, "_row"},   32'(s.m_row),   32'(beat / int'(N)));
      chk({tag, "_col"},   32'(s.m_col),   32'(beat % int'(N)));
      chk({tag, "_last"},  32'(s.m_last),  32'(beat == int'(N * N) - 1));
      if (s.m_ready) beat++;
      @(negedge clock);
      cyc++;
    end
    done_in = hold;
    nbeats  = beat;
    ncyc    = cyc;
  endtask

  int nb, nc;

  initial begin
    reset     = 1'b1;
    done_in   = 1'b0;
    s.m_ready = 1'b0;
    fill(0);
    @(negedge clock);
    chk_idle("reset");
    chk("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Frame with m_ready held high: exactly 25 cycles, then valid drops
    done_in = 1'b1;
    @(negedge clock);
    drain("f1", 0, 0, -1, -1, 0, 1'b0, nb, nc);
    chk("f1_beats", 32'(nb), 32'd25);
    chk("f1_cycles", 32'(nc), 32'd25);
    chk_idle("f1_after");

    // Same frame with m_ready toggling 1,0,0,1
    done_in = 1'b1;
    @(negedge clock);
    drain("f2", 0, 1, -1, -1, 0, 1'b0, nb, nc);
    chk("f2_beats", 32'(nb), 32'd25);
    chk_idle("f2_after");

    // fmap_in changes two cycles after start: frame still carries the snapshot
    done_in = 1'b1;
    @(negedge clock);
    drain("f3", 0, 0, -1, 2, 1, 1'b0, nb, nc);
    chk("f3_beats", 32'(nb), 32'd25);
    chk_idle("f3_after");
    done_in = 1'b1;
    @(negedge clock);
    drain("f3neg", 1, 0, -1, -1, 0, 1'b0, nb, nc);
    chk("f3neg_beats", 32'(nb), 32'd25);

    // Start at beat 7 while busy: overrun, current frame unchanged, no second frame
    fill(0);
    done_in = 1'b1;
    @(negedge clock);
    drain("f4", 0, 0, 7, -1, 0, 1'b0, nb, nc);
    chk("f4_beats", 32'(nb), 32'd25);
    chk("f4_overrun", 32'(overrun), 32'd1);
    repeat (5) begin
      chk("f4_nosecond", 32'(s.m_valid), 32'd0);
      @(negedge clock);
    end
    chk("f4_overrun_sticky", 32'(overrun), 32'd1);

    reset = 1'b1;
    @(negedge clock);
    chk("rst2_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Start on the final handshake: no bubble, new snapshot, no overrun
    fill(0);
    done_in = 1'b1;
    @(negedge clock);
    drain("f5a", 0, 0, 24, 3, 2, 1'b0, nb, nc);
    chk("f5a_beats", 32'(nb), 32'd25);
    chk("f5_overrun", 32'(overrun), 32'd0);
    drain("f5b", 2, 0, -1, -1, 0, 1'b0, nb, nc);
    chk("f5b_beats", 32'(nb), 32'd25);
    chk("f5b_overrun", 32'(overrun), 32'd0);
    chk_idle("f5_after");

    // Asynchronous reset at beat 12, done_in held high through release
    fill(0);
    done_in = 1'b1;
    @(negedge clock);
    done_in   = 1'b0;
    s.m_ready = 1'b1;
    repeat (12) @(negedge clock);
    chk("f6_row12", 32'(s.m_row), 32'd2);
    chk("f6_col12", 32'(s.m_col), 32'd2);
    done_in = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("f6_async_valid", 32'(s.m_valid), 32'd0);
    chk("f6_async_busy",  32'(busy),      32'd0);
    chk("f6_async_row",   32'(s.m_row),   32'd0);
    chk("f6_async_col",   32'(s.m_col),   32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("f6_held_nostart", 32'(s.m_valid), 32'd0);
    end
    done_in = 1'b0;
    @(negedge clock);
    done_in = 1'b1;
    @(negedge clock);
    drain("f6", 0, 0, -1, -1, 0, 1'b1, nb, nc);
    chk("f6_beats", 32'(nb), 32'd25);
    repeat (4) begin
      chk("f6_one_frame", 32'(s.m_valid), 32'd0);
      @(negedge clock);
    end
    done_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
